instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Sequential RV32I instruction encoder and instruction-memory loader: the inverse of the control unit's main decoder. It accepts decoded instruction fields (class, registers, funct3, immediate) over a valid/ready handshake, encodes them into 32-bit machine words using the same opcode map the decoder consumes, and writes them to consecutive instruction-memory words. It boots test programs into instruction memory before the core leaves reset, and it checks field legality so malformed programs are flagged rather than silently loaded.

## Interface
- ADDR_WIDTH, 8, word-address width of instruction memory; depth = 2^ADDR_WIDTH words
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a new program at word address 0, clears done/err
- finish  in  1  pulse; ends the current program (sampled in ACCEPT only)
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- in_class  in  3  0 LOAD, 1 STORE, 2 OPIMM, 3 OP, 4 BRANCH, 5 JAL, 6 JALR, 7 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3 field
- in_funct7b5  in  1  instruction bit 30 for OP and OPIMM shifts
- in_imm  in  32  signed immediate, byte offset for BRANCH/JAL
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_WIDTH+1  words written in the current program
- busy  out  1  high in ACCEPT or WRITE
- done  out  1  sticky; set when the program ends cleanly
- err  out  1  sticky; set on an illegal bundle

## Operation
- Opcodes: LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011, BRANCH 1100011, JAL 1101111, JALR 1100111.
- I format (LOAD, OPIMM, JALR): imm[11:0] rs1 f3 rd op. JALR forces f3=000. OPIMM with f3=101 places funct7b5 at bit 30 and imm[4:0] as shamt.
- S: imm[11:5] rs2 rs1 f3 imm[4:0] op.
- B: imm[12] imm[10:5] rs2 rs1 f3 imm[4:1] imm[11] op.
- J: imm[20] imm[10:1] imm[11] imm[19:12] rd op.
- R: {1'b0, funct7b5, 5'b0} rs2 rs1 f3 rd op.
- Legality checks; any failure sets err:
  - class 7 is illegal.
  - I/S imm must lie in [-2048, 2047].
  - B imm must lie in [-4096, 4094] with bit 0 = 0.
  - J imm must lie in [-2^20, 2^20-2] with bit 0 = 0.
  - OPIMM shift (f3=001/101) requires imm in [0, 31].
- FSM states: IDLE, ACCEPT, WRITE, DONE, ERR.
  - IDLE: in_ready=0. start → ACCEPT, ptr←0.
  - ACCEPT: in_ready=1. A handshake with a legal bundle latches the encoded word → WRITE. A handshake with an illegal bundle → ERR, nothing written. finish with no handshake → DONE. If handshake and finish coincide, the handshake wins and finish is dropped.
  - WRITE: mem_we=1, mem_addr=ptr, mem_wdata=latched word; ptr and count increment. Next state is DONE if count becomes 2^ADDR_WIDTH, else ACCEPT.
  - DONE / ERR: outputs hold; start → ACCEPT, and the flags clear.
- start outside IDLE/DONE/ERR is ignored.

## Timing
- Reset values: state IDLE; in_ready, mem_we, busy, done, err = 0; mem_addr, mem_wdata, count = 0.
- Latency: handshake in cycle N produces mem_we in cycle N+1. Sustained throughput is one word per 2 cycles.
- in_ready is a registered state decode and does not depend combinationally on in_valid.
- Memory full: after word 2^ADDR_WIDTH-1 is written, count = 2^ADDR_WIDTH and done=1. ptr never wraps.
- done and err are mutually exclusive.
- rst_n asserted mid-WRITE: mem_we drops immediately (async) and the partial program is abandoned.

## Structure
- Package instr_pkg: instr_class_t enum, the seven opcode localparams, fsm state enum. This is the same opcode set the main decoder switches on, so both blocks share it.
- Sub-module instr_encode: purely combinational fields → {word, illegal}. The top holds the FSM, pointer, and output registers.

## Test plan
- addi x1,x0,5 (class 2, rd=1, rs1=0, f3=0, imm=5) after start → one cycle later mem_we=1, addr=0, wdata=0x00500093, count=1.
- sw x2,8(x1) then sub x3,x1,x2 (class 3, funct7b5=1) → 0x0020A423 at addr 0, 0x402081B3 at addr 1.
- beq x0,x0,-4 → 0xFE000EE3. jal x0,8 → 0x0080006F.
- BRANCH with imm=3 (odd) → err=1 next cycle, no mem_we, in_ready=0. start → err cleared, ptr=0.
- ADDR_WIDTH=2: four legal bundles → addrs 0..3 written, count=4, done=1, in_ready=0. A fifth in_valid is never accepted.
- finish in ACCEPT with count=2 → done=1. rst_n pulsed low during WRITE → mem_we=0 at once and all outputs return to reset values.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared RV32I definitions: instruction classes, major opcodes and loader FSM states.
// The main decoder switches on the same opcode set, so both blocks import this package.
package instr_pkg;

    typedef enum logic [2:0] {
        CLS_LOAD    = 3'd0,
        CLS_STORE   = 3'd1,
        CLS_OPIMM   = 3'd2,
        CLS_OP      = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_JALR    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instr_class_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Inclusive signed range test used by the immediate legality checks.
    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I field encoder: decoded fields in, machine word and legality flag out.
module instr_encode
    import instr_pkg::*;
(
    input  logic [2:0]  cls_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic signed [31:0] imm_s;
    assign imm_s = imm_i;

    // Format selection by class, with the per-format immediate range checks.
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (instr_class_t'(cls_i))
            CLS_LOAD: begin
                word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
                illegal_o = !in_range(imm_s, -32'sd2048, 32'sd2047);
            end
            CLS_STORE: begin
                word_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
                illegal_o = !in_range(imm_s, -32'sd2048, 32'sd2047);
            end
            CLS_OPIMM: begin
                if (funct3_i == 3'b101) begin
                    word_o    = {1'b0, funct7b5_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
                    illegal_o = !in_range(imm_s, 32'sd0, 32'sd31);
                end else if (funct3_i == 3'b001) begin
                    word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
                    illegal_o = !in_range(imm_s, 32'sd0, 32'sd31);
                end else begin
                    word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
                    illegal_o = !in_range(imm_s, -32'sd2048, 32'sd2047);
                end
            end
            CLS_OP: begin
                word_o = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
            end
            CLS_BRANCH: begin
                word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], OPC_BRANCH};
                illegal_o = !in_range(imm_s, -32'sd4096, 32'sd4094) || imm_i[0];
            end
            CLS_JAL: begin
                word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
                illegal_o = !in_range(imm_s, -32'sd1048576, 32'sd1048574) || imm_i[0];
            end
            CLS_JALR: begin
                word_o    = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
                illegal_o = !in_range(imm_s, -32'sd2048, 32'sd2047);
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction-memory loader: accepts field bundles, encodes them and writes
// consecutive words starting at address 0; flags malformed bundles via err.
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_class,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7b5,
    input  logic [31:0]           in_imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q;
    logic                  in_ready_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        handshake;

    instr_encode u_encode (
        .cls_i      (in_class),
        .rd_i       (in_rd),
        .rs1_i      (in_rs1),
        .rs2_i      (in_rs2),
        .funct3_i   (in_funct3),
        .funct7b5_i (in_funct7b5),
        .imm_i      (in_imm),
        .word_o     (enc_word),
        .illegal_o  (enc_illegal)
    );

    assign handshake = in_valid && in_ready_q;

    // Loader FSM; every output is registered alongside the state. count is
    // bumped on the handshake edge so it already reflects the word during mem_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_q    <= ST_ACCEPT;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        count_q    <= '0;
                    end
                end
                ST_ACCEPT: begin
                    if (handshake) begin
                        in_ready_q <= 1'b0;
                        if (enc_illegal) begin
                            state_q <= ST_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= ST_WRITE;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= count_q[ADDR_WIDTH-1:0];
                            mem_wdata_q <= enc_word;
                            count_q     <= count_q + CNT_ONE;
                        end
                    end else if (finish) begin
                        state_q    <= ST_DONE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (count_q == DEPTH) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_ACCEPT;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed table, corner sequences,
// and randomized bundles checked against an arithmetic encoding model.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cls = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  f3 = '0;
    logic        f7 = 1'b0;
    logic [31:0] imm = '0;

    logic        start_a = 1'b0, finish_a = 1'b0, valid_a = 1'b0;
    logic        ready_a, we_a, busy_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [8:0]  count_a;

    logic        start_b = 1'b0, finish_b = 1'b0, valid_b = 1'b0;
    logic        ready_b, we_b, busy_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_cnt = 0;

    instr_encoder_loader #(.ADDR_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .finish(finish_a),
        .in_valid(valid_a), .in_ready(ready_a), .in_class(cls), .in_rd(rd),
        .in_rs1(rs1), .in_rs2(rs2), .in_funct3(f3), .in_funct7b5(f7), .in_imm(imm),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .count(count_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    instr_encoder_loader #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .finish(finish_b),
        .in_valid(valid_b), .in_ready(ready_b), .in_class(cls), .in_rd(rd),
        .in_rs1(rs1), .in_rs2(rs2), .in_funct3(f3), .in_funct7b5(f7), .in_imm(imm),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .count(count_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          fresh;
        int          c, d, s1, s2, fn3, fn7;
        longint      im;
        logic [31:0] w;
        bit          ill;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Encoding written from the instruction formats with plain arithmetic.
    function automatic void model(input int c, input longint d, input longint s1, input longint s2,
                                  input longint fn3, input longint fn7, input longint im,
                                  output logic [31:0] w, output bit ill);
        longint v;
        bit     i_bad;
        v = 0;
        i_bad = (im < -2048) || (im > 2047);
        ill = 1'b0;
        case (c)
            0: begin ill = i_bad; v = ((im & 4095) << 20) + (s1 << 15) + (fn3 << 12) + (d << 7) + 3; end
            1: begin ill = i_bad; v = (((im >> 5) & 127) << 25) + (s2 << 20) + (s1 << 15) + (fn3 << 12) + ((im & 31) << 7) + 35; end
            2: begin
                if (fn3 == 1 || fn3 == 5) begin
                    ill = (im < 0) || (im > 31);
                    v = ((fn3 == 5) ? (fn7 << 30) : 0) + ((im & 31) << 20) + (s1 << 15) + (fn3 << 12) + (d << 7) + 19;
                end else begin
                    ill = i_bad;
                    v = ((im & 4095) << 20) + (s1 << 15) + (fn3 << 12) + (d << 7) + 19;
                end
            end
            3: v = (fn7 << 30) + (s2 << 20) + (s1 << 15) + (fn3 << 12) + (d << 7) + 51;
            4: begin
                ill = (im < -4096) || (im > 4094) || (im % 2 != 0);
                v = (((im >> 12) & 1) << 31) + (((im >> 5) & 63) << 25) + (s2 << 20) + (s1 << 15)
                    + (fn3 << 12) + (((im >> 1) & 15) << 8) + (((im >> 11) & 1) << 7) + 99;
            end
            5: begin
                ill = (im < -1048576) || (im > 1048574) || (im % 2 != 0);
                v = (((im >> 20) & 1) << 31) + (((im >> 1) & 1023) << 21) + (((im >> 11) & 1) << 20)
                    + (((im >> 12) & 255) << 12) + (d << 7) + 111;
            end
            6: begin ill = i_bad; v = ((im & 4095) << 20) + (s1 << 15) + (d << 7) + 103; end
            default: ill = 1'b1;
        endcase
        w = v[31:0];
    endfunction

    task automatic wait_ready_a();
        int t = 0;
        while (!ready_a && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!ready_a) chk("ready_timeout", ready_a, 1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        exp_cnt = 0;
        chk("start_err_clr", err_a, 0);
        chk("start_done_clr", done_a, 0);
        chk("start_count0", count_a, 0);
        chk("start_ready", ready_a, 1);
    endtask

    task automatic finish_a_now(input string tag);
        wait_ready_a();
        finish_a = 1'b1;
        @(negedge clk);
        finish_a = 1'b0;
        chk({tag, "_done"}, done_a, 1);
        chk({tag, "_err"}, err_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_ready"}, ready_a, 0);
        chk({tag, "_count"}, count_a, 64'(exp_cnt));
    endtask

    // One bundle through DUT A, then the cycle-after checks for write or error.
    task automatic send_a(input string name, input int c, input int d, input int s1, input int s2,
                          input int fn3, input int fn7, input longint im,
                          input logic [31:0] exp_w, input bit exp_ill, input bit with_fin);
        wait_ready_a();
        cls = 3'(c); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
        f3 = 3'(fn3); f7 = 1'(fn7); imm = im[31:0];
        valid_a = 1'b1;
        finish_a = with_fin;
        @(negedge clk);
        valid_a = 1'b0;
        finish_a = 1'b0;
        if (!exp_ill) begin
            chk({name, "_we"}, we_a, 1);
            chk({name, "_addr"}, addr_a, 64'(exp_cnt));
            chk({name, "_wdata"}, wdata_a, exp_w);
            exp_cnt++;
            chk({name, "_count"}, count_a, 64'(exp_cnt));
            chk({name, "_busy"}, busy_a, 1);
            @(negedge clk);
            chk({name, "_we_drop"}, we_a, 0);
            chk({name, "_ready_again"}, ready_a, 1);
            chk({name, "_nodone"}, done_a, 0);
        end else begin
            chk({name, "_no_we"}, we_a, 0);
            chk({name, "_err"}, err_a, 1);
            chk({name, "_ready0"}, ready_a, 0);
            chk({name, "_done0"}, done_a, 0);
            chk({name, "_count_hold"}, count_a, 64'(exp_cnt));
            pulse_start_a();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] mw;
        bit          mi;

        tbl.push_back('{"addi5",   1, 2, 1, 0, 0, 0, 0, 5,        32'h00500093, 0});
        tbl.push_back('{"sw",      1, 1, 0, 1, 2, 2, 0, 8,        32'h0020A423, 0});
        tbl.push_back('{"sub",     0, 3, 3, 1, 2, 0, 1, 0,        32'h402081B3, 0});
        tbl.push_back('{"beq_m4",  0, 4, 0, 0, 0, 0, 0, -4,       32'hFE000EE3, 0});
        tbl.push_back('{"jal8",    0, 5, 0, 0, 0, 0, 0, 8,        32'h0080006F, 0});
        tbl.push_back('{"addi_max",0, 2, 1, 0, 0, 0, 0, 2047,     32'h7FF00093, 0});
        tbl.push_back('{"addi_min",0, 2, 1, 0, 0, 0, 0, -2048,    32'h80000093, 0});
        tbl.push_back('{"slli31",  0, 2, 5, 6, 0, 1, 0, 31,       32'h01F31293, 0});
        tbl.push_back('{"srai3",   0, 2, 5, 6, 0, 5, 1, 3,        32'h40335293, 0});
        tbl.push_back('{"jalr_f3", 0, 6, 1, 2, 0, 3, 0, 0,        32'h000100E7, 0});
        tbl.push_back('{"lw_m4",   0, 0, 4, 5, 0, 2, 0, -4,       32'hFFC2A203, 0});
        tbl.push_back('{"sw_min",  0, 1, 0, 0, 0, 2, 0, -2048,    32'h80002023, 0});
        tbl.push_back('{"b_max",   0, 4, 0, 0, 0, 0, 0, 4094,     32'h7E000FE3, 0});
        tbl.push_back('{"b_min",   0, 4, 0, 0, 0, 0, 0, -4096,    32'h80000063, 0});
        tbl.push_back('{"j_max",   0, 5, 0, 0, 0, 0, 0, 1048574,  32'h7FFFF06F, 0});
        tbl.push_back('{"b_odd",   0, 4, 0, 0, 0, 0, 0, 3,        32'h0, 1});
        tbl.push_back('{"addi_hi", 0, 2, 1, 0, 0, 0, 0, 2048,     32'h0, 1});
        tbl.push_back('{"addi_lo", 0, 2, 1, 0, 0, 0, 0, -2049,    32'h0, 1});
        tbl.push_back('{"sw_hi",   0, 1, 0, 1, 2, 2, 0, 2048,     32'h0, 1});
        tbl.push_back('{"b_hi",    0, 4, 0, 0, 0, 0, 0, 4096,     32'h0, 1});
        tbl.push_back('{"b_lo",    0, 4, 0, 0, 0, 0, 0, -4098,    32'h0, 1});
        tbl.push_back('{"j_hi",    0, 5, 0, 0, 0, 0, 0, 1048576,  32'h0, 1});
        tbl.push_back('{"j_odd",   0, 5, 0, 0, 0, 0, 0, 5,        32'h0, 1});
        tbl.push_back('{"slli32",  0, 2, 1, 1, 0, 1, 0, 32,       32'h0, 1});
        tbl.push_back('{"srli_neg",0, 2, 1, 1, 0, 5, 0, -1,       32'h0, 1});
        tbl.push_back('{"class7",  0, 7, 1, 1, 1, 0, 0, 0,        32'h0, 1});

        repeat (3) @(negedge clk);
        chk("rst_ready", ready_a, 0);
        chk("rst_we", we_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_wdata", wdata_a, 0);
        chk("rst_count", count_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", ready_a, 0);
        chk("idle_busy", busy_a, 0);
        pulse_start_a();

        // Directed table.
        foreach (tbl[i]) begin
            if (tbl[i].fresh) begin
                finish_a_now({tbl[i].name, "_fin"});
                pulse_start_a();
            end
            send_a(tbl[i].name, tbl[i].c, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].fn3, tbl[i].fn7,
                   tbl[i].im, tbl[i].w, tbl[i].ill, 1'b0);
        end

        // Start in ACCEPT is ignored; finish with two words ends cleanly.
        finish_a_now("pre_fin");
        pulse_start_a();
        send_a("w0", 2, 1, 0, 0, 0, 0, 1, 32'h00100093, 0, 0);
        send_a("w1", 2, 1, 0, 0, 0, 0, 2, 32'h00200093, 0, 0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("start_ign_count", count_a, 2);
        chk("start_ign_ready", ready_a, 1);
        finish_a_now("fin2");

        // Handshake and finish together: write wins, program continues.
        pulse_start_a();
        send_a("hs_fin", 3, 3, 1, 2, 0, 1, 0, 32'h402081B3, 0, 1);

        // Asynchronous reset during WRITE.
        wait_ready_a();
        cls = 3'd2; rd = 5'd1; rs1 = 5'd0; f3 = 3'd0; imm = 32'd5;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        chk("wr_before_rst_we", we_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_we", we_a, 0);
        chk("async_rst_count", count_a, 0);
        chk("async_rst_addr", addr_a, 0);
        chk("async_rst_wdata", wdata_a, 0);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_ready", ready_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", ready_a, 0);

        // Memory-full on the 4-word instance.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int t = 0;
            while (!ready_b && t < 20) begin @(negedge clk); t++; end
            chk("full_ready", ready_b, 1);
            cls = 3'd2; rd = 5'd1; rs1 = 5'd0; f3 = 3'd0; imm = 32'(i);
            valid_b = 1'b1;
            @(negedge clk);
            valid_b = 1'b0;
            chk("full_we", we_b, 1);
            chk("full_addr", addr_b, 64'(i));
            chk("full_count", count_b, 64'(i + 1));
        end
        @(negedge clk);
        chk("full_done", done_b, 1);
        chk("full_ready0", ready_b, 0);
        chk("full_count4", count_b, 4);
        chk("full_busy0", busy_b, 0);
        chk("full_err0", err_b, 0);
        valid_b = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("full_no_accept_we", we_b, 0);
            chk("full_no_accept_ready", ready_b, 0);
        end
        valid_b = 1'b0;
        chk("full_count_hold", count_b, 4);

        // Randomized bundles against the model.
        pulse_start_a();
        for (int n = 0; n < 250; n++) begin
            int     c, d, s1, s2, fn3, fn7, mode;
            longint im;
            c = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, 31));
            s1 = int'($urandom_range(0, 31));
            s2 = int'($urandom_range(0, 31));
            fn3 = int'($urandom_range(0, 7));
            fn7 = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 4));
            case (mode)
                0: im = longint'(int'($urandom_range(0, 80))) - 40;
                1: im = longint'(int'($urandom_range(2040, 2055))) * (($urandom_range(0, 1) != 0) ? -1 : 1);
                2: im = longint'(int'($urandom_range(4088, 4103))) * (($urandom_range(0, 1) != 0) ? -1 : 1);
                3: im = longint'(int'($urandom_range(1048568, 1048583))) * (($urandom_range(0, 1) != 0) ? -1 : 1);
                default: im = longint'($signed($urandom));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 14) == 0) begin
                finish_a_now("rnd_fin");
                pulse_start_a();
            end else begin
                model(c, d, s1, s2, fn3, fn7, im, mw, mi);
                send_a("rnd", c, d, s1, s2, fn3, fn7, im, mw, mi, $urandom_range(0, 9) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
